// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - clk1 frequency qualifier and glitch-free clock-mux select controller
`timescale 1ns/1ps
module clk_sel_ctrl #(
  parameter int WIN_CYCLES    = 1024,
  parameter int DIV_LOG2      = 3,
  parameter int MIN_EDGES     = 120,
  parameter int MAX_EDGES     = 136,
  parameter int GOOD_WINDOWS  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk_0_i,
  input  logic             arst_n_i,
  input  logic             clk_1_i,
  input  logic             switch_en_i,
  input  logic             fault_clr_i,
  output logic             sel_o,
  output logic             clk1_ok_o,
  output logic             switching_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] freq_cnt_o
);

  localparam int WIN_W  = $clog2(WIN_CYCLES);
  localparam int SET_W  = $clog2(SETTLE_CYCLES) + 1;
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);

  localparam logic [1:0] ST_CLK0  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_CLK1  = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;

  logic [DIV_LOG2-1:0] pre_cnt;
  logic                tap_q;
  logic [2:0]          sync_q;
  logic                edge_det;
  logic [WIN_W-1:0]    win_cnt;
  logic                win_end;
  logic [CNT_W-1:0]    edge_cnt;
  logic [CNT_W-1:0]    edge_sum;
  logic                win_good;
  logic [GOOD_W-1:0]   good_cnt;
  logic [GOOD_W-1:0]   good_inc;
  logic [GOOD_W-1:0]   good_nxt;
  logic [SET_W-1:0]    settle_cnt;
  logic                settle_done;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                sel_q;
  logic                sel_nxt;
  logic                fault_q;
  logic                fault_set;
  logic                ok_q;
  logic [CNT_W-1:0]    freq_q;

  // clk1 domain: prescaler tap is registered so only a flop output crosses domains
  always_ff @(posedge clk_1_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pre_cnt <= '0;
      tap_q   <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tap_q   <= pre_cnt[DIV_LOG2-1];
    end
  end

  assign edge_det    = sync_q[1] ^ sync_q[2];
  assign win_end     = (win_cnt == WIN_W'(WIN_CYCLES - 1));
  assign edge_sum    = (edge_det && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
  assign win_good    = (edge_sum >= CNT_W'(MIN_EDGES)) && (edge_sum <= CNT_W'(MAX_EDGES));
  assign good_inc    = (good_cnt == GOOD_W'(GOOD_WINDOWS)) ? good_cnt : good_cnt + 1'b1;
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign switching_o = (state == ST_WAIT1) || (state == ST_WAIT0);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    fault_set = 1'b0;
    case (state)
      ST_CLK0: begin
        if (switch_en_i && win_end && win_good && (good_inc == GOOD_W'(GOOD_WINDOWS))) begin
          state_nxt = ST_WAIT1;
          sel_nxt   = 1'b1;
        end
      end
      ST_WAIT1: begin
        if (win_end && !win_good) begin
          state_nxt = ST_WAIT0;
          sel_nxt   = 1'b0;
          fault_set = 1'b1;
        end else if (settle_done) begin
          state_nxt = ST_CLK1;
        end
      end
      ST_CLK1: begin
        if (win_end && !win_good) begin
          state_nxt = ST_WAIT0;
          sel_nxt   = 1'b0;
          fault_set = 1'b1;
        end else if (!switch_en_i) begin
          state_nxt = ST_WAIT0;
          sel_nxt   = 1'b0;
        end
      end
      ST_WAIT0: begin
        if (settle_done) state_nxt = ST_CLK0;
      end
      default: begin
        state_nxt = ST_CLK0;
        sel_nxt   = 1'b0;
      end
    endcase
  end

  // entering WAIT0 discards qualification history so requalification starts from zero
  always_comb begin
    good_nxt = good_cnt;
    if (win_end) good_nxt = win_good ? good_inc : '0;
    if ((state_nxt == ST_WAIT0) && (state != ST_WAIT0)) good_nxt = '0;
  end

  always_ff @(posedge clk_0_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q     <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      freq_q     <= '0;
      ok_q       <= 1'b0;
      good_cnt   <= '0;
      settle_cnt <= '0;
      state      <= ST_CLK0;
      sel_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], tap_q};
      win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
      edge_cnt <= win_end ? '0 : edge_sum;
      if (win_end) begin
        freq_q <= edge_sum;
        ok_q   <= win_good;
      end
      good_cnt <= good_nxt;
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      if (state_nxt != state) settle_cnt <= '0;
      else if (switching_o)   settle_cnt <= settle_cnt + 1'b1;
      if (fault_set)        fault_q <= 1'b1;
      else if (fault_clr_i) fault_q <= 1'b0;
    end
  end

  assign sel_o      = sel_q;
  assign clk1_ok_o  = ok_q;
  assign fault_o    = fault_q;
  assign freq_cnt_o = freq_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - directed self-checking bench for clk_sel_ctrl
`timescale 1ns/1ps
module tb_clk_sel_ctrl;

  logic        clk_0     = 1'b0;
  logic        clk_1     = 1'b0;
  logic        arst_n    = 1'b0;
  logic        switch_en = 1'b0;
  logic        fault_clr = 1'b0;
  logic        sel;
  logic        clk1_ok;
  logic        switching;
  logic        fault;
  logic [15:0] freq_cnt;

  real half1    = 10.0;
  bit  clk1_run = 1'b1;
  int  cyc      = 0;
  int  n_chk    = 0;
  int  n_fail   = 0;

  clk_sel_ctrl #(
    .WIN_CYCLES(64), .DIV_LOG2(2), .MIN_EDGES(14), .MAX_EDGES(18),
    .GOOD_WINDOWS(4), .SETTLE_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk_0_i(clk_0), .arst_n_i(arst_n), .clk_1_i(clk_1),
    .switch_en_i(switch_en), .fault_clr_i(fault_clr),
    .sel_o(sel), .clk1_ok_o(clk1_ok), .switching_o(switching),
    .fault_o(fault), .freq_cnt_o(freq_cnt)
  );

  always #5 clk_0 = ~clk_0;

  // clk1 edges stay at 2 or 4.5 ns mod 5 for both 10 and 12.5 ns half periods, never on a clk0 edge
  initial begin
    #2;
    forever begin
      #(half1);
      if (clk1_run) clk_1 = ~clk_1;
    end
  end

  always @(posedge clk_0 or negedge arst_n)
    if (!arst_n) cyc <= 0;
    else         cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk_0);
  endtask

  initial begin
    switch_en = 1'b1;
    #50;
    check("rst_sel", sel, 0);
    check("rst_ok", clk1_ok, 0);
    check("rst_sw", switching, 0);
    check("rst_fault", fault, 0);
    check("rst_freq", freq_cnt, 0);
    #50 arst_n = 1'b1;

    goto(63);  check("w1_pre_freq", freq_cnt, 0); check("w1_pre_ok", clk1_ok, 0);
    goto(64);  check("w1_freq", freq_cnt, 15);    check("w1_ok", clk1_ok, 1);
    goto(128); check("w2_freq", freq_cnt, 16);
    goto(255); check("pre_sw_sel", sel, 0);
    goto(256); check("sw_sel", sel, 1); check("sw_wait1", switching, 1);
    goto(263); check("wait1_last", switching, 1);
    goto(264); check("clk1_sw", switching, 0); check("clk1_sel", sel, 1);

    goto(320); check("w5_freq", freq_cnt, 16); check("w5_ok", clk1_ok, 1);
    clk1_run = 1'b0;
    goto(383); check("stop_pre_sel", sel, 1); check("stop_pre_fault", fault, 0);
    goto(384);
    check("stop_freq", freq_cnt, 0); check("stop_ok", clk1_ok, 0);
    check("stop_sel", sel, 0); check("stop_fault", fault, 1); check("stop_sw", switching, 1);
    goto(391); check("wait0_last", switching, 1);
    goto(392); check("wait0_done", switching, 0); check("clk0_sel", sel, 0);

    fault_clr = 1'b1;
    goto(393); fault_clr = 1'b0;
    check("fault_clr", fault, 0);

    half1 = 12.5; clk1_run = 1'b1;
    for (int w = 7; w <= 16; w++) begin
      goto(64 * w);
      check($sformatf("slow_sel_w%0d", w), sel, 0);
      check($sformatf("slow_ok_w%0d", w), clk1_ok, 0);
      check($sformatf("slow_fault_w%0d", w), fault, 0);
    end
    check("slow_freq", (freq_cnt == 12) || (freq_cnt == 13), 1);

    clk1_run = 1'b0;
    goto(1088); check("gap_ok", clk1_ok, 0);
    half1 = 10.0; clk1_run = 1'b1;
    goto(1152); check("rest_w1_ok", clk1_ok, 1);
    check("rest_w1_freq", (freq_cnt >= 14) && (freq_cnt <= 16), 1);
    goto(1216); check("rest_w2_freq", freq_cnt, 16);
    goto(1343); check("rest_pre_sel", sel, 0);
    goto(1344); check("rest_sel", sel, 1);
    goto(1352); check("rest_clk1_sw", switching, 0); check("rest_clk1_sel", sel, 1);

    goto(1360); switch_en = 1'b0;
    goto(1361); check("drop_sel", sel, 0); check("drop_sw", switching, 1); check("drop_fault", fault, 0);
    goto(1362); switch_en = 1'b1;
    goto(1364); switch_en = 1'b0;
    goto(1365); check("pulse_sel", sel, 0); check("pulse_sw", switching, 1);
    goto(1368); check("drop_wait0_last", switching, 1);
    goto(1369); check("drop_done_sw", switching, 0); check("drop_done_sel", sel, 0);
    switch_en = 1'b1;

    goto(1599); check("req_pre_sel", sel, 0);
    goto(1600); check("req_sel", sel, 1);
    goto(1664); check("req_ok", clk1_ok, 1);
    clk1_run = 1'b0;
    goto(1727); check("coinc_pre_fault", fault, 0); check("coinc_pre_sel", sel, 1);
    fault_clr = 1'b1;
    goto(1728); fault_clr = 1'b0;
    check("coinc_fault", fault, 1); check("coinc_sel", sel, 0);
    check("coinc_ok", clk1_ok, 0); check("coinc_freq", freq_cnt <= 1, 1);
    clk1_run = 1'b1;

    goto(1983); check("f_pre_sel", sel, 0);
    goto(1984); check("f_sel", sel, 1); check("f_sw", switching, 1);
    goto(1987);
    arst_n = 1'b0;
    #1;
    check("arst_sel", sel, 0);
    check("arst_sw", switching, 0);
    check("arst_freq", freq_cnt, 0);
    check("arst_fault", fault, 0);
    check("arst_ok", clk1_ok, 0);
    @(negedge clk_0) arst_n = 1'b1;
    goto(64);  check("re_w1_ok", clk1_ok, 1);
    goto(192); check("re_w3_sel", sel, 0);
    goto(255); check("re_pre_sel", sel, 0);
    goto(256); check("re_sel", sel, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
- Monitors the secondary clock clk_1_i against the local reference clk_0_i, qualifies its frequency, and generates the clock-mux select (1 = clk1, 0 = clk0).
- Switches to clk1 only after sustained good measurements.
- Falls back to clk0 immediately when clk1 is lost or goes off-frequency, and flags a sticky fault.
- Sits in the clock/reset wrapper; sel_o drives the glitch-free clock mux select input.

Parameters:
- WIN_CYCLES, 1024: measurement window length in clk_0_i cycles (≥16).
- DIV_LOG2, 3: clk_1_i prescaler; the monitored toggle is bit DIV_LOG2-1 of a clk1-domain counter, giving one edge per 2^(DIV_LOG2-1) clk1 cycles.
- MIN_EDGES, 120: minimum synchronized edges per window for a good window.
- MAX_EDGES, 136: maximum synchronized edges per window for a good window.
- GOOD_WINDOWS, 4: consecutive good windows required before switching to clk1.
- SETTLE_CYCLES, 16: clk_0_i cycles held in a switching state after sel_o changes.
- CNT_W, 16: width of the edge counter and freq_cnt_o.

Ports:
- clk_0_i  in  1  reference clock; all logic except the prescaler runs here.
- arst_n_i  in  1  asynchronous active-low reset, used in both clock domains.
- clk_1_i  in  1  monitored clock; clocks only the prescaler.
- switch_en_i  in  1  software request to run on clk1 (clk_0 domain, level).
- fault_clr_i  in  1  single-cycle pulse that clears fault_o.
- sel_o  out  1  mux select; 1 = clk1.
- clk1_ok_o  out  1  result of the last completed window (1 = good).
- switching_o  out  1  high while in WAIT1 or WAIT0.
- fault_o  out  1  sticky; set on a forced fallback from clk1.
- freq_cnt_o  out  CNT_W  edge count latched at the end of the last window.

Behaviour:
- Reset: arst_n_i asynchronous, active-low; clock clk_0_i. Reset values: sel_o=0, clk1_ok_o=0, switching_o=0, fault_o=0, freq_cnt_o=0, FSM=CLK0, all counters 0, synchronizer flops 0. The clk1 prescaler is also reset asynchronously by arst_n_i.
- Prescaler: DIV_LOG2-bit up-counter on clk_1_i, wrapping. The tap bit is registered before leaving the domain.
- Synchronizer and edge detect:
  - Tap passes through a 3-flop synchronizer in clk_0_i.
  - Edge = XOR of flops 2 and 3; both rising and falling edges count.
  - Latency from tap change to edge pulse: 3 clk_0 cycles.
- Window counter:
  - Counts 0..WIN_CYCLES-1 and wraps.
  - Edge counter saturates at 2^CNT_W-1.
  - On the terminal cycle: freq_cnt_o <= edges including any edge in that cycle; clk1_ok_o <= (MIN_EDGES ≤ count ≤ MAX_EDGES); edge counter restarts at 0.
  - "Window end" below means this terminal cycle.
- Good-window counter: at each window end, incremented if good (saturating at GOOD_WINDOWS), cleared to 0 if bad.
- FSM, all state changes on clk_0_i:
  - CLK0: sel_o=0. If switch_en_i=1 and the good counter reaches GOOD_WINDOWS at a window end → WAIT1 and set sel_o=1 that cycle.
  - WAIT1: switching_o=1; settle counter runs SETTLE_CYCLES cycles, then → CLK1. A bad window end here → WAIT0 with fault set.
  - CLK1: sel_o=1.
    - Bad window end → WAIT0, sel_o=0 and fault_o=1 on the same edge.
    - switch_en_i=0 → WAIT0 with no fault.
  - WAIT0: switching_o=1; sel_o=0; after SETTLE_CYCLES → CLK0. The good counter is cleared on entry, so requalification restarts from zero.
- switch_en_i changes during WAIT1/WAIT0 are ignored until the state completes.
- fault_o: set and fault_clr_i in the same cycle → set wins. fault_clr_i is otherwise a clear.
- clk1 stopped: edge count stays 0, so the window is bad and fallback occurs at the next window end. Worst-case detection latency is WIN_CYCLES+3 cycles.
- Reset mid-operation: everything returns to reset values immediately; sel_o=0 asynchronously.

Test Plan:
- Test parameters: WIN_CYCLES=64, DIV_LOG2=2, MIN=14, MAX=18, GOOD=4, SETTLE=8. Clocks: clk0 100 MHz, clk1 50 MHz, giving 16 edges/window.
- Reset then switch_en_i=1 → freq_cnt_o=16 (±1 on the first window) and clk1_ok_o=1. sel_o rises at the 4th good window end; switching_o is high for exactly 8 cycles; then CLK1.
- In CLK1, stop clk1 → the next window end gives freq_cnt_o=0 and clk1_ok_o=0. sel_o=0 and fault_o=1 on the same edge, then WAIT0 for 8 cycles, then CLK0.
- clk1 at 40 MHz (≈13 edges, below MIN) with switch_en_i=1 for 10 windows → sel_o stays 0 and fault_o stays 0. Restoring 50 MHz → sel_o=1 after 4 further good windows.
- In CLK1, drop switch_en_i → WAIT0 and sel_o=0 next cycle with fault_o=0. Pulse switch_en_i during WAIT0 → no effect; the state completes to CLK0.
- fault_o=1 with fault_clr_i pulsed alone → 0 next cycle. fault_clr_i coincident with a new fault event → fault_o stays 1.
- Assert arst_n_i low mid-WAIT1 → sel_o, switching_o and freq_cnt_o go to 0 immediately. On release, operation restarts from CLK0 and needs 4 fresh good windows.
